// File: rtl/key_pkg.sv
// Shared types and helpers for the key event front end.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } key_st_t;

  // Bits needed to hold 0..v; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned v);
    return (v == 0) ? 32'd1 : 32'($clog2(v + 32'd1));
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key: synchroniser, debounce, press classification FSM and hold/repeat counters.
module key_channel
  import key_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = 1_000_000,
  parameter int unsigned LONG_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_state,
  output logic press_p,
  output logic release_p,
  output logic click_p,
  output logic long_p,
  output logic repeat_p
);

  localparam int unsigned DB_W     = cnt_w(DB_CYCLES);
  localparam int unsigned HOLD_W   = cnt_w(LONG_CYCLES);
  localparam int unsigned REP_W    = cnt_w(REPEAT_CYCLES);
  localparam int unsigned REP_LAST = (REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1;

  localparam logic              IDLE_LVL = ACTIVE_LOW;
  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_MAX  = REP_W'(REP_LAST);

  logic [1:0]        sync_q, sync_d;
  logic              smp_q, smp_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              key_state_q, key_state_d;
  key_st_t           st_q, st_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [REP_W-1:0]  rep_q, rep_d;
  logic              press_q, press_d, release_q, release_d, click_q, click_d;
  logic              long_q, long_d, repeat_q, repeat_d;
  logic              accept_c, acc_press_c, acc_rel_c;

  always_comb begin
    sync_d      = {sync_q[0], key_in};
    smp_d       = sync_q[1] ^ IDLE_LVL;
    db_cnt_d    = db_cnt_q;
    key_state_d = key_state_q;
    st_d        = st_q;
    hold_d      = hold_q;
    rep_d       = rep_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    click_d     = 1'b0;
    long_d      = 1'b0;
    repeat_d    = 1'b0;
    accept_c    = 1'b0;

    // Debounce: a level change is accepted after DB_CYCLES disagreeing samples in a row.
    if (smp_q == key_state_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_MAX) begin
      key_state_d = ~key_state_q;
      db_cnt_d    = '0;
      accept_c    = 1'b1;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
    acc_press_c = accept_c & ~key_state_q;
    acc_rel_c   = accept_c & key_state_q;

    // Release is checked first so it wins over a coincident long or repeat tick.
    case (st_q)
      IDLE: begin
        hold_d = '0;
        rep_d  = '0;
        if (acc_press_c) begin
          st_d    = PRESSED;
          press_d = 1'b1;
        end
      end
      PRESSED: begin
        if (acc_rel_c) begin
          st_d      = IDLE;
          release_d = 1'b1;
          click_d   = 1'b1;
          hold_d    = '0;
        end else if (hold_q == HOLD_MAX) begin
          st_d   = LONG;
          long_d = 1'b1;
          hold_d = '0;
          rep_d  = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      LONG: begin
        if (acc_rel_c) begin
          st_d      = IDLE;
          release_d = 1'b1;
          rep_d     = '0;
        end else if (REPEAT_CYCLES != 0) begin
          if (rep_q == REP_MAX) begin
            repeat_d = 1'b1;
            rep_d    = '0;
          end else begin
            rep_d = rep_q + REP_W'(1);
          end
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= {2{IDLE_LVL}};
      smp_q       <= 1'b0;
      db_cnt_q    <= '0;
      key_state_q <= 1'b0;
      st_q        <= IDLE;
      hold_q      <= '0;
      rep_q       <= '0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      click_q     <= 1'b0;
      long_q      <= 1'b0;
      repeat_q    <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      smp_q       <= smp_d;
      db_cnt_q    <= db_cnt_d;
      key_state_q <= key_state_d;
      st_q        <= st_d;
      hold_q      <= hold_d;
      rep_q       <= rep_d;
      press_q     <= press_d;
      release_q   <= release_d;
      click_q     <= click_d;
      long_q      <= long_d;
      repeat_q    <= repeat_d;
    end
  end

  assign key_state = key_state_q;
  assign press_p   = press_q;
  assign release_p = release_q;
  assign click_p   = click_q;
  assign long_p    = long_q;
  assign repeat_p  = repeat_q;

endmodule

// File: rtl/key_event_unit.sv
// Multi-key front end: one independent key_channel per input bit.
module key_event_unit
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS        = 4,
  parameter int unsigned DB_CYCLES     = 1_000_000,
  parameter int unsigned LONG_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] press_p,
  output logic [N_KEYS-1:0] release_p,
  output logic [N_KEYS-1:0] click_p,
  output logic [N_KEYS-1:0] long_p,
  output logic [N_KEYS-1:0] repeat_p
);

  for (genvar g = 0; g < int'(N_KEYS); g++) begin : g_ch
    key_channel #(
      .DB_CYCLES    (DB_CYCLES),
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .key_in   (key_in[g]),
      .key_state(key_state[g]),
      .press_p  (press_p[g]),
      .release_p(release_p[g]),
      .click_p  (click_p[g]),
      .long_p   (long_p[g]),
      .repeat_p (repeat_p[g])
    );
  end

endmodule
